// File: rtl/writeback_queue.sv
// Writeback queue: forms the register-file writeback value from the selected source
// and buffers up to two {value, rd} entries. Optional load alignment: WB_LOAD_ALIGN_EN.
module writeback_queue #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_enable,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      wb_select,
    input  logic [XLEN-1:0] upper_immediate,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] csr_data,
    input  logic [XLEN-3:0] return_addr,
    input  logic [1:0]      load_size,
    input  logic            load_unsigned,
    input  logic [1:0]      load_offset,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pre_wb,
    output logic [RD_W-1:0] rd_out,
    output logic            misalign_flag
);

    localparam logic [2:0] SEL_UP   = 3'b000;
    localparam logic [2:0] SEL_ALU  = 3'b001;
    localparam logic [2:0] SEL_RET  = 3'b010;
    localparam logic [2:0] SEL_LOAD = 3'b011;
    localparam logic [2:0] SEL_CSR  = 3'b100;

    logic [1:0]      count_reg, count_next;
    logic [XLEN-1:0] value_reg [2];
    logic [XLEN-1:0] value_next [2];
    logic [RD_W-1:0] rd_reg [2];
    logic [RD_W-1:0] rd_next [2];
    logic            misalign_reg, misalign_next;

    logic [XLEN-1:0] load_value;
    logic            load_misaligned;
    logic [XLEN-1:0] wb_value;
    logic            accept, push, pop;

`ifdef WB_LOAD_ALIGN_EN
    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [63:0] ext_value;
    logic        sign_fill;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = load_data[8*gi +: 8];
        end
    endgenerate

    // Extension is built at 64 bits and truncated so XLEN = 32 needs no zero-width replication.
    always_comb begin
        load_value      = '0;
        load_misaligned = 1'b0;
        ext_value       = '0;
        sel_byte        = byte_lane[load_offset];
        sel_half        = load_offset[1] ? load_data[31:16] : load_data[15:0];
        sign_fill       = 1'b0;
        case (load_size)
            2'b00: begin
                sign_fill = ~load_unsigned & sel_byte[7];
                ext_value = {{56{sign_fill}}, sel_byte};
            end
            2'b01: begin
                sign_fill = ~load_unsigned & sel_half[15];
                ext_value = {{48{sign_fill}}, sel_half};
                load_misaligned = load_offset[0];
            end
            default: begin
                sign_fill = ~load_unsigned & load_data[31];
                ext_value = {{32{sign_fill}}, load_data[31:0]};
                load_misaligned = (load_offset != 2'b00);
            end
        endcase
        load_value = load_misaligned ? '0 : ext_value[XLEN-1:0];
    end
`else
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{load_size, load_unsigned, load_offset};
    assign load_value       = load_data;
    assign load_misaligned  = 1'b0;
`endif

    always_comb begin
        case (wb_select)
            SEL_UP:   wb_value = upper_immediate;
            SEL_ALU:  wb_value = alu_out;
            SEL_RET:  wb_value = {return_addr, 2'b00};
            SEL_LOAD: wb_value = load_value;
            SEL_CSR:  wb_value = csr_data;
            default:  wb_value = '0;
        endcase
    end

    // No refill while full, even if the head pops this cycle.
    assign in_ready  = clk_enable && (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (rd_in != '0);
    assign pop       = out_valid && out_ready && clk_enable;

    assign pre_wb        = value_reg[0];
    assign rd_out        = rd_reg[0];
    assign misalign_flag = misalign_reg;

    // Slot 0 is the head; it keeps its last contents when the queue drains.
    always_comb begin
        count_next    = count_reg;
        value_next[0] = value_reg[0];
        value_next[1] = value_reg[1];
        rd_next[0]    = rd_reg[0];
        rd_next[1]    = rd_reg[1];
        misalign_next = misalign_reg | (accept && (wb_select == SEL_LOAD) && load_misaligned);
        if (push && pop) begin
            value_next[0] = wb_value;
            rd_next[0]    = rd_in;
        end else if (push) begin
            count_next = count_reg + 2'd1;
            if (count_reg == 2'd0) begin
                value_next[0] = wb_value;
                rd_next[0]    = rd_in;
            end else begin
                value_next[1] = wb_value;
                rd_next[1]    = rd_in;
            end
        end else if (pop) begin
            count_next = count_reg - 2'd1;
            if (count_reg == 2'd2) begin
                value_next[0] = value_reg[1];
                rd_next[0]    = rd_reg[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg    <= 2'd0;
            value_reg[0] <= '0;
            value_reg[1] <= '0;
            rd_reg[0]    <= '0;
            rd_reg[1]    <= '0;
            misalign_reg <= 1'b0;
        end else if (clk_enable) begin
            count_reg    <= count_next;
            value_reg[0] <= value_next[0];
            value_reg[1] <= value_next[1];
            rd_reg[0]    <= rd_next[0];
            rd_reg[1]    <= rd_next[1];
            misalign_reg <= misalign_next;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: vector table of single pushes plus
// hand-written sequences for backpressure, x0 drop, misalignment, enable and reset.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n, clk_enable, in_valid, in_ready;
    logic [2:0]  wb_select;
    logic [31:0] upper_immediate, alu_out, load_data, csr_data;
    logic [29:0] return_addr;
    logic [1:0]  load_size, load_offset;
    logic        load_unsigned;
    logic [4:0]  rd_in, rd_out;
    logic        out_valid, out_ready, misalign_flag;
    logic [31:0] pre_wb;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_queue #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_ready(in_ready), .wb_select(wb_select),
        .upper_immediate(upper_immediate), .alu_out(alu_out),
        .load_data(load_data), .csr_data(csr_data), .return_addr(return_addr),
        .load_size(load_size), .load_unsigned(load_unsigned),
        .load_offset(load_offset), .rd_in(rd_in), .out_valid(out_valid),
        .out_ready(out_ready), .pre_wb(pre_wb), .rd_out(rd_out),
        .misalign_flag(misalign_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [31:0] ui, alu, ld, csr;
        logic [29:0] ra;
        logic [1:0]  size, off;
        logic        uns;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string name, input logic [2:0] sel, input logic [31:0] ui,
                       input logic [31:0] alu, input logic [29:0] ra, input logic [31:0] ld,
                       input logic [31:0] csr, input logic [1:0] size, input logic uns,
                       input logic [1:0] off, input logic [4:0] rd, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.sel = sel; v.ui = ui; v.alu = alu; v.ra = ra; v.ld = ld;
        v.csr = csr; v.size = size; v.uns = uns; v.off = off; v.rd = rd; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_alu(input logic [31:0] val, input logic [4:0] rd);
        wb_select = 3'b001; alu_out = val; rd_in = rd; in_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        wb_select = 3'b000; upper_immediate = '0; alu_out = '0; load_data = '0;
        csr_data = '0; return_addr = '0; load_size = '0; load_offset = '0;
        load_unsigned = 1'b0; rd_in = '0;

        add("ret_addr", 3'b010, 32'h1111_1111, 32'h2222_2222, 30'h1, 32'h3, 32'h4,
            2'b10, 1'b0, 2'b00, 5'd1, 32'h0000_0004);
        add("upper",    3'b000, 32'h1234_5000, 32'h2222_2222, 30'h7, 32'h3, 32'h4,
            2'b10, 1'b0, 2'b00, 5'd2, 32'h1234_5000);
        add("alu",      3'b001, 32'h1111_1111, 32'hCAFE_BABE, 30'h7, 32'h3, 32'h4,
            2'b10, 1'b0, 2'b00, 5'd31, 32'hCAFE_BABE);
        add("csr",      3'b100, 32'h1111_1111, 32'h2222_2222, 30'h7, 32'h3, 32'h0000_0300,
            2'b10, 1'b0, 2'b00, 5'd7, 32'h0000_0300);
        add("rsv101",   3'b101, 32'h1111_1111, 32'h2222_2222, 30'h7, 32'h3, 32'h4,
            2'b10, 1'b0, 2'b00, 5'd4, 32'h0000_0000);
        add("rsv111",   3'b111, 32'h1111_1111, 32'h2222_2222, 30'h7, 32'h3, 32'h4,
            2'b10, 1'b0, 2'b00, 5'd5, 32'h0000_0000);
`ifdef WB_LOAD_ALIGN_EN
        add("lb_s_off1", 3'b011, 0, 0, 0, 32'h0000_80FF, 0, 2'b00, 1'b0, 2'b01, 5'd10, 32'hFFFF_FF80);
        add("lb_u_off1", 3'b011, 0, 0, 0, 32'h0000_80FF, 0, 2'b00, 1'b1, 2'b01, 5'd11, 32'h0000_0080);
        add("lh_s_off2", 3'b011, 0, 0, 0, 32'h8001_1234, 0, 2'b01, 1'b0, 2'b10, 5'd12, 32'hFFFF_8001);
        add("lw_off0",   3'b011, 0, 0, 0, 32'h8765_4321, 0, 2'b10, 1'b0, 2'b00, 5'd13, 32'h8765_4321);
        add("lb_u_off3", 3'b011, 0, 0, 0, 32'hA500_0000, 0, 2'b00, 1'b1, 2'b11, 5'd14, 32'h0000_00A5);
`else
        add("lb_s_off1", 3'b011, 0, 0, 0, 32'h0000_80FF, 0, 2'b00, 1'b0, 2'b01, 5'd10, 32'h0000_80FF);
        add("lb_u_off1", 3'b011, 0, 0, 0, 32'h0000_80FF, 0, 2'b00, 1'b1, 2'b01, 5'd11, 32'h0000_80FF);
        add("lh_s_off2", 3'b011, 0, 0, 0, 32'h8001_1234, 0, 2'b01, 1'b0, 2'b10, 5'd12, 32'h8001_1234);
        add("lw_off0",   3'b011, 0, 0, 0, 32'h8765_4321, 0, 2'b10, 1'b0, 2'b00, 5'd13, 32'h8765_4321);
        add("lb_u_off3", 3'b011, 0, 0, 0, 32'hA500_0000, 0, 2'b00, 1'b1, 2'b11, 5'd14, 32'hA500_0000);
`endif

        // Reset state
        @(negedge clk); step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pre_wb", pre_wb, 32'd0);
        check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        check("rst_misalign", {31'd0, misalign_flag}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // Vector table: one push into an empty queue, observe, pop
        foreach (vq[i]) begin
            wb_select = vq[i].sel; upper_immediate = vq[i].ui; alu_out = vq[i].alu;
            return_addr = vq[i].ra; load_data = vq[i].ld; csr_data = vq[i].csr;
            load_size = vq[i].size; load_unsigned = vq[i].uns; load_offset = vq[i].off;
            rd_in = vq[i].rd; in_valid = 1'b1; out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            check({vq[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({vq[i].name, "_pre_wb"}, pre_wb, vq[i].exp);
            check({vq[i].name, "_rd"}, {27'd0, rd_out}, {27'd0, vq[i].rd});
            $display("vec %s: pre_wb=%h rd_out=%0d", vq[i].name, pre_wb, rd_out);
            out_ready = 1'b1;
            step();
            check({vq[i].name, "_popped"}, {31'd0, out_valid}, 32'd0);
            out_ready = 1'b0;
        end

        // Backpressure: fill to two, third held until a slot frees
        push_alu(32'd5, 5'd3);
        step();
        push_alu(32'd6, 5'd3);
        check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
        check("bp_head5", pre_wb, 32'd5);
        step();
        push_alu(32'd7, 5'd3);
        check("bp_ready_full", {31'd0, in_ready}, 32'd0);
        step();
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        check("bp_head_held", pre_wb, 32'd5);
        out_ready = 1'b1;
        step();
        $display("txn pop: pre_wb=%h", pre_wb);
        check("bp_head6", pre_wb, 32'd6);
        check("bp_ready_again", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_head7", pre_wb, 32'd7);
        check("bp_valid7", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        check("bp_hold_last", pre_wb, 32'd7);
        out_ready = 1'b0;

        // x0 destination is dropped
        push_alu(32'h0000_DEAD, 5'd0);
        step();
        in_valid = 1'b0;
        $display("txn x0 push: out_valid=%0d", out_valid);
        check("x0_valid", {31'd0, out_valid}, 32'd0);
        check("x0_ready", {31'd0, in_ready}, 32'd1);
        check("x0_pre_wb", pre_wb, 32'd7);

        // Misaligned half load
        wb_select = 3'b011; load_data = 32'h1234_5678; load_size = 2'b01;
        load_offset = 2'b01; load_unsigned = 1'b0; rd_in = 5'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        $display("txn misaligned lh: pre_wb=%h flag=%0d", pre_wb, misalign_flag);
`ifdef WB_LOAD_ALIGN_EN
        check("mis_pre_wb", pre_wb, 32'd0);
        check("mis_flag", {31'd0, misalign_flag}, 32'd1);
`else
        check("mis_pre_wb", pre_wb, 32'h1234_5678);
        check("mis_flag", {31'd0, misalign_flag}, 32'd0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        push_alu(32'd3, 5'd2);
        step();
        in_valid = 1'b0;
`ifdef WB_LOAD_ALIGN_EN
        check("mis_sticky", {31'd0, misalign_flag}, 32'd1);
`else
        check("mis_sticky", {31'd0, misalign_flag}, 32'd0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Two queued, enable low, then reset with enable still low
        push_alu(32'd11, 5'd5);
        step();
        push_alu(32'd22, 5'd6);
        step();
        in_valid = 1'b0;
        check("en_queued_head", pre_wb, 32'd11);
        clk_enable = 1'b0; out_ready = 1'b1;
        push_alu(32'd33, 5'd7);
        for (int c = 0; c < 3; c++) begin
            step();
            check("en_hold_valid", {31'd0, out_valid}, 32'd1);
            check("en_hold_pre_wb", pre_wb, 32'd11);
            check("en_hold_rd", {27'd0, rd_out}, 32'd5);
            check("en_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        $display("txn reset: out_valid=%0d pre_wb=%h", out_valid, pre_wb);
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_pre_wb", pre_wb, 32'd0);
        check("rst2_misalign", {31'd0, misalign_flag}, 32'd0);
        rst_n = 1'b1; clk_enable = 1'b1;
        step();
        check("rst2_empty", {31'd0, out_valid}, 32'd0);
        check("rst2_ready", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
